ppu_sprite_tile_eval: RTL and testbench

Per-tile sprite evaluator that sits directly upstream of `ppu_vram_load_fsm`. On `start`, it scans all 64 OAM entries for the 8x8 tile whose top-left pixel is (`curr_row`, `curr_col`). It selects the first two sprites, in OAM index order, that overlap that tile and presents them on the `sprite_0_*` / `sprite_1_*` ports the load FSM consumes. Results are committed atomically at the end of the scan, so the outputs are stable while the load FSM runs.

---
 rtl/ppu_sprite_tile_eval.sv | 211 +++++++++++++++++++++
 tb/tb_ppu_sprite_tile_eval.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_sprite_tile_eval.sv
// ppu_sprite_tile_eval
//   Scans every OAM entry for one 8x8 tile whose top-left pixel is
//   (curr_row, curr_col), keeps the first two overlapping sprites in OAM
//   index order, and commits them atomically for ppu_vram_load_fsm.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start                 : evaluation request, sampled only in IDLE
//   curr_row, curr_col    : tile origin, latched on an accepted start
//   ppu_ctrl2             : bit 4 = sprite enable, latched on accepted start
//   oam_addr / oam_data   : synchronous OAM read port ({index, byte})
//   sprite_{0,1}_*        : committed slot contents (valid, tile, Y, X, attr)
//   sprite_overflow       : more than two sprites overlapped the tile
//   busy                  : evaluation in progress
//   done                  : one-cycle pulse, outputs updated on the same edge

module ppu_sprite_tile_eval #(
  parameter int unsigned OAM_ENTRIES   = 64,
  parameter logic [7:0]  SPRITE_HIDE_Y = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] curr_row,
  input  logic [8:0] curr_col,
  input  logic [7:0] ppu_ctrl2,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_data,
  output logic       sprite_0_on_tile,
  output logic [7:0] sprite_0_tile_num,
  output logic [7:0] sprite_0_row,
  output logic [7:0] sprite_0_col,
  output logic [7:0] sprite_0_attr,
  output logic       sprite_1_on_tile,
  output logic [7:0] sprite_1_tile_num,
  output logic [7:0] sprite_1_row,
  output logic [7:0] sprite_1_col,
  output logic [7:0] sprite_1_attr,
  output logic       sprite_overflow,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LAST_ADDR = 8'(4 * OAM_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] tile;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] attr;
  } slot_t;

  state_t     state;
  logic [8:0] tr;
  logic [8:0] tc;
  logic       en;

  // Byte index of the data arriving on oam_data this cycle.
  logic       rd_valid;
  logic [1:0] rd_byte;

  logic [7:0] w_y;
  logic [7:0] w_tile;
  logic [7:0] w_attr;

  slot_t      w_s0, w_s1;
  logic       w_ovf;
  slot_t      s0_next, s1_next;
  logic       ovf_next;

  slot_t      out_s0, out_s1;
  logic       out_ovf;

  logic       eval_now;
  logic       hit;
  logic [9:0] y10, x10, tr10, tc10;
  slot_t      cand;

  // Working-slot update for the entry whose X byte is on oam_data now.
  // Also feeds the commit on the DRAIN edge so the final entry is included.
  always_comb begin
    eval_now = rd_valid && (rd_byte == 2'd3) && ((state == SCAN) || (state == DRAIN));
    y10  = {2'b00, w_y};
    x10  = {2'b00, oam_data};
    tr10 = {1'b0, tr};
    tc10 = {1'b0, tc};
    hit  = eval_now
        && (w_y < SPRITE_HIDE_Y)
        && ((y10 + 10'd8) > tr10) && (y10 < (tr10 + 10'd8))
        && ((x10 + 10'd8) > tc10) && (x10 < (tc10 + 10'd8));

    cand.valid = 1'b1;
    cand.tile  = w_tile;
    cand.row   = w_y;
    cand.col   = oam_data;
    cand.attr  = w_attr;

    s0_next  = w_s0;
    s1_next  = w_s1;
    ovf_next = w_ovf;
    if (hit) begin
      if (!w_s0.valid)      s0_next  = cand;
      else if (!w_s1.valid) s1_next  = cand;
      else                  ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tr       <= '0;
      tc       <= '0;
      en       <= 1'b0;
      oam_addr <= '0;
      rd_valid <= 1'b0;
      rd_byte  <= '0;
      w_y      <= '0;
      w_tile   <= '0;
      w_attr   <= '0;
      w_s0     <= '0;
      w_s1     <= '0;
      w_ovf    <= 1'b0;
      out_s0   <= '0;
      out_s1   <= '0;
      out_ovf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_valid <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            tr    <= curr_row;
            tc    <= curr_col;
            en    <= ppu_ctrl2[4];
            w_s0  <= '0;
            w_s1  <= '0;
            w_ovf <= 1'b0;
            busy  <= 1'b1;
            if (ppu_ctrl2[4]) begin
              state    <= SCAN;
              oam_addr <= '0;
            end else begin
              // Disabled: commit empty slots immediately, no OAM traffic.
              state   <= COMMIT;
              out_s0  <= '0;
              out_s1  <= '0;
              out_ovf <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (rd_valid) begin
            case (rd_byte)
              2'd0:    w_y    <= oam_data;
              2'd1:    w_tile <= oam_data;
              2'd2:    w_attr <= oam_data;
              default: ;
            endcase
          end
          w_s0     <= s0_next;
          w_s1     <= s1_next;
          w_ovf    <= ovf_next;
          rd_valid <= 1'b1;
          rd_byte  <= oam_addr[1:0];
          if (oam_addr == LAST_ADDR) state    <= DRAIN;
          else                       oam_addr <= oam_addr + 8'd1;
        end

        DRAIN: begin
          w_s0     <= s0_next;
          w_s1     <= s1_next;
          w_ovf    <= ovf_next;
          rd_valid <= 1'b0;
          out_s0   <= s0_next;
          out_s1   <= s1_next;
          out_ovf  <= ovf_next;
          done     <= 1'b1;
          state    <= COMMIT;
        end

        COMMIT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign sprite_0_on_tile  = out_s0.valid;
  assign sprite_0_tile_num = out_s0.tile;
  assign sprite_0_row      = out_s0.row;
  assign sprite_0_col      = out_s0.col;
  assign sprite_0_attr     = out_s0.attr;
  assign sprite_1_on_tile  = out_s1.valid;
  assign sprite_1_tile_num = out_s1.tile;
  assign sprite_1_row      = out_s1.row;
  assign sprite_1_col      = out_s1.col;
  assign sprite_1_attr     = out_s1.attr;
  assign sprite_overflow   = out_ovf;

endmodule

// File: tb/tb_ppu_sprite_tile_eval.sv
module tb_ppu_sprite_tile_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] curr_row;
  logic [8:0] curr_col;
  logic [7:0] ppu_ctrl2;
  logic [7:0] oam_addr;
  logic [7:0] oam_data;
  logic       sprite_0_on_tile, sprite_1_on_tile;
  logic [7:0] sprite_0_tile_num, sprite_0_row, sprite_0_col, sprite_0_attr;
  logic [7:0] sprite_1_tile_num, sprite_1_row, sprite_1_col, sprite_1_attr;
  logic       sprite_overflow;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] oam [256];

  typedef struct packed {
    logic       v0;
    logic [7:0] t0, r0, c0, a0;
    logic       v1;
    logic [7:0] t1, r1, c1, a1;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) oam_data <= oam[oam_addr];

  ppu_sprite_tile_eval #(.OAM_ENTRIES(64), .SPRITE_HIDE_Y(8'hF0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .curr_row(curr_row), .curr_col(curr_col), .ppu_ctrl2(ppu_ctrl2),
    .oam_addr(oam_addr), .oam_data(oam_data),
    .sprite_0_on_tile(sprite_0_on_tile), .sprite_0_tile_num(sprite_0_tile_num),
    .sprite_0_row(sprite_0_row), .sprite_0_col(sprite_0_col), .sprite_0_attr(sprite_0_attr),
    .sprite_1_on_tile(sprite_1_on_tile), .sprite_1_tile_num(sprite_1_tile_num),
    .sprite_1_row(sprite_1_row), .sprite_1_col(sprite_1_col), .sprite_1_attr(sprite_1_attr),
    .sprite_overflow(sprite_overflow), .busy(busy), .done(done)
  );

  // Reference: first two overlapping, non-hidden entries in index order.
  function automatic exp_t model(input int tr, input int tc, input logic en);
    exp_t e;
    int   y, x, cnt;
    e   = '0;
    cnt = 0;
    if (en) begin
      for (int i = 0; i < 64; i++) begin
        y = int'(oam[4*i]);
        x = int'(oam[4*i+3]);
        if (y < 240 && y + 8 > tr && y < tr + 8 && x + 8 > tc && x < tc + 8) begin
          if (cnt == 0) begin
            e.v0 = 1'b1; e.t0 = oam[4*i+1]; e.r0 = oam[4*i]; e.c0 = oam[4*i+3]; e.a0 = oam[4*i+2];
          end else if (cnt == 1) begin
            e.v1 = 1'b1; e.t1 = oam[4*i+1]; e.r1 = oam[4*i]; e.c1 = oam[4*i+3]; e.a1 = oam[4*i+2];
          end else begin
            e.ovf = 1'b1;
          end
          cnt++;
        end
      end
    end
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = {sprite_0_on_tile, sprite_0_tile_num, sprite_0_row, sprite_0_col, sprite_0_attr,
         sprite_1_on_tile, sprite_1_tile_num, sprite_1_row, sprite_1_col, sprite_1_attr,
         sprite_overflow};
    return a;
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) begin
      oam[4*i] = 8'hFF; oam[4*i+1] = 8'h00; oam[4*i+2] = 8'h00; oam[4*i+3] = 8'h00;
    end
  endtask

  task automatic set_entry(input int i, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
    oam[4*i] = y; oam[4*i+1] = t; oam[4*i+2] = a; oam[4*i+3] = x;
  endtask

  task automatic kick(input int row, input int col, input logic [7:0] ctrl, input bit now);
    if (!now) @(negedge clk);
    curr_row  = 9'(row);
    curr_col  = 9'(col);
    ppu_ctrl2 = ctrl;
    start     = 1'b1;
    sb.push_back(model(row, col, ctrl[4]));
  endtask

  // Waits for done, scores latency and the committed outputs; ends on the
  // negedge of the IDLE cycle that follows COMMIT.
  task automatic wait_done(input string name, input int exp_lat, input int pulse_at);
    exp_t e, a;
    int   lat;
    bit   got;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_c1 got %b want 1", name, busy);
        end
      end
      if (n == 2) begin
        curr_row = 9'h1FF; curr_col = 9'h1FF; ppu_ctrl2 = 8'h00;
      end
      if (pulse_at != 0 && n == pulse_at) start = 1'b1;
      if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1; lat = n; break;
      end
    end
    checks++;
    if (!got || lat != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d (seen=%0d)", name, lat, exp_lat, got);
    end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL %s scoreboard empty got 0 want 1", name);
    end else begin
      e = sb.pop_front();
      a = actual();
      checks++;
      if (a[66:34] !== e[66:34]) begin
        errors++; $display("FAIL %s slot0 got %h want %h", name, a[66:34], e[66:34]);
      end
      checks++;
      if (a[33:1] !== e[33:1]) begin
        errors++; $display("FAIL %s slot1 got %h want %h", name, a[33:1], e[33:1]);
      end
      checks++;
      if (a.ovf !== e.ovf) begin
        errors++; $display("FAIL %s overflow got %b want %b", name, a.ovf, e.ovf);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; curr_row = '0; curr_col = '0; ppu_ctrl2 = '0;
    clear_oam();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (actual() !== '0 || busy !== 1'b0 || done !== 1'b0 || oam_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset outs=%h busy=%b done=%b addr=%h want all 0", actual(), busy, done, oam_addr);
    end
  endtask

  task automatic test_two_sprites();
    clear_oam();
    set_entry(3, 8'd0, 8'd0, 8'd0, 8'd3);
    set_entry(7, 8'd0, 8'd1, 8'd1, 8'd14);
    kick(0, 8, 8'h18, 1'b0);
    wait_done("two_sprites", 258, 0);
    checks++;
    if ({sprite_0_on_tile, sprite_0_col, sprite_1_on_tile, sprite_1_tile_num, sprite_1_col, sprite_1_attr}
        !== {1'b1, 8'd3, 1'b1, 8'd1, 8'd14, 8'd1}) begin
      errors++; $display("FAIL two_sprites fields col0=%0d col1=%0d tile1=%0d attr1=%0d want 3 14 1 1",
                         sprite_0_col, sprite_1_col, sprite_1_tile_num, sprite_1_attr);
    end
  endtask

  task automatic test_disabled();
    logic [7:0] addr_before;
    addr_before = oam_addr;
    kick(0, 8, 8'h00, 1'b0);
    wait_done("disabled", 1, 0);
    checks++;
    if (oam_addr !== 8'hFF || addr_before !== 8'hFF) begin
      errors++; $display("FAIL disabled oam_addr got %h want ff", oam_addr);
    end
  endtask

  task automatic test_edges();
    int tbl [8][5] = '{
      '{0,   8, 0,   1,  1}, '{0,   8, 0,   0,  0},
      '{0,   8, 0,   15, 1}, '{0,   8, 0,   16, 0},
      '{0,   0, 7,   0,  1}, '{0,   0, 8,   0,  0},
      '{240, 0, 240, 0,  0}, '{240, 0, 239, 0,  1}
    };
    for (int k = 0; k < 8; k++) begin
      clear_oam();
      set_entry(10, 8'(tbl[k][2]), 8'h55, 8'h03, 8'(tbl[k][3]));
      kick(tbl[k][0], tbl[k][1], 8'h10, 1'b0);
      wait_done($sformatf("edge%0d", k), 258, 0);
      checks++;
      if (sprite_0_on_tile !== 1'(tbl[k][4])) begin
        errors++; $display("FAIL edge%0d hit got %b want %0d", k, sprite_0_on_tile, tbl[k][4]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_oam();
    set_entry(2, 8'd16, 8'hA2, 8'h22, 8'd16);
    set_entry(5, 8'd20, 8'hA5, 8'h25, 8'd10);
    set_entry(9, 8'd12, 8'hA9, 8'h29, 8'd20);
    kick(16, 16, 8'h10, 1'b0);
    wait_done("overflow", 258, 0);
    checks++;
    if ({sprite_0_tile_num, sprite_1_tile_num, sprite_overflow} !== {8'hA2, 8'hA5, 1'b1}) begin
      errors++; $display("FAIL overflow slots got %h %h %b want a2 a5 1",
                         sprite_0_tile_num, sprite_1_tile_num, sprite_overflow);
    end
  endtask

  task automatic test_reset_mid();
    exp_t dummy;
    bit   stray;
    clear_oam();
    set_entry(4, 8'd0, 8'h44, 8'h01, 8'd2);
    kick(0, 0, 8'h10, 1'b0);
    for (int n = 1; n <= 101; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 100) rst = 1'b1;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || actual() !== '0 || oam_addr !== 8'h00) begin
      errors++; $display("FAIL reset_mid busy=%b done=%b outs=%h addr=%h want 0", busy, done, actual(), oam_addr);
    end
    rst   = 1'b0;
    dummy = sb.pop_front();
    stray = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL reset_mid stray_done got 1 want 0");
    end
    kick(0, 0, 8'h10, 1'b0);
    wait_done("after_reset", 258, 0);
  endtask

  task automatic test_start_during_scan();
    clear_oam();
    set_entry(0, 8'd100, 8'h11, 8'h02, 8'd50);
    set_entry(63, 8'd104, 8'h22, 8'h03, 8'd45);
    kick(100, 48, 8'h10, 1'b0);
    wait_done("start_in_scan", 258, 50);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_in_scan restarted busy got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_oam();
    set_entry(1, 8'd30, 8'h31, 8'h41, 8'd60);
    kick(32, 56, 8'h10, 1'b0);
    wait_done("b2b_first", 258, 0);
    set_entry(6, 8'd33, 8'h36, 8'h46, 8'd61);
    kick(32, 56, 8'h10, 1'b1);
    wait_done("b2b_second", 258, 0);
  endtask

  initial begin
    test_reset();
    test_two_sprites();
    test_disabled();
    test_edges();
    test_overflow();
    test_start_during_scan();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
